reg_writeback_queue: RTL
========================

// Module: reg_writeback_queue
// PURPOSE
//  Collects register writeback results from two producers and serialises them onto the single
//  register-file write port (write_en/dest/write_val), one entry per cycle, in arrival order.
//  Port A is the ALU/fast writeback path; port B is the load/mul-div (long-latency) path.
//  A small FIFO absorbs same-cycle collisions and pipeline stalls.
// PARAMETERS
//  QUEUE_DEPTH        4  entries in the writeback FIFO; power of 2, >=2
//  STARVE_LIMIT       3  consecutive B-lost arbitrations before B takes priority; >=1
//  REG_FILE_ADDR_LEN  5  register address width
//  (data width is `WORD_SIZE from definitions.sv)
// PORTS
//  clk        in   1                       clock
//  rst        in   1                       reset: synchronous, active-high
//  a_valid    in   1                       port A request
//  a_ready    out  1                       port A accepted this cycle when a_valid&&a_ready
//  a_dest     in   REG_FILE_ADDR_LEN       port A destination register
//  a_data     in   `WORD_SIZE              port A data
//  b_valid    in   1                       port B request
//  b_ready    out  1                       port B accept
//  b_dest     in   REG_FILE_ADDR_LEN       port B destination register
//  b_data     in   `WORD_SIZE              port B data
//  stall      in   1                       freeze drain; no register-file write this cycle
//  write_en   out  1                       register-file write strobe
//  dest       out  REG_FILE_ADDR_LEN       register-file write address
//  write_val  out  `WORD_SIZE              register-file write data
//  occupancy  out  $clog2(QUEUE_DEPTH)+1   entries currently held
// BEHAVIOUR
//  - Reset: FIFO flushed, occupancy=0, write_en=0, dest=0, write_val=0, starve count=0.
//    Reset mid-operation discards all pending entries; none reach the register file.
//  - Drain: write_en = (occupancy!=0) && !stall; dest/write_val = FIFO head (combinational).
//    Head pops on the same edge. write_en=0 forces dest=0 and write_val=0.
//  - Latency: request accepted at edge N -> write_en/dest/write_val at cycle N+1 (queue empty, no stall).
//  - free = QUEUE_DEPTH - occupancy, taken at the start of the cycle. A same-cycle pop does not add space.
//  - free>=2: both ports ready. If both fire, A is enqueued first (older), then B.
//  - free==1: one port only.
//    - Default: a_ready=1, b_ready=!a_valid.
//    - If starve==STARVE_LIMIT: b_ready=1, a_ready=!b_valid.
//  - free==0: a_ready=b_ready=0. Readies depend combinationally on valids and occupancy only.
//  - Starve counter:
//    - +1 in each cycle where b_valid=1, b_ready=0 and free==1 (B lost to A).
//    - Cleared on B acceptance or b_valid=0.
//    - Held when free==0. Saturates at STARVE_LIMIT.
//  - dest==0: the handshake completes but nothing is enqueued; occupancy is unchanged and no write is issued.
//  - Occupancy next = occupancy + enqueues(0..2) - pop(0..1). It never exceeds QUEUE_DEPTH and never underflows.
//  - Pointers wrap modulo QUEUE_DEPTH. Entries are written to the register file strictly in enqueue order.
// CONFIGURATION
//  BYPASS_EN defined: adds ports
//    byp_src1/byp_src2  in   REG_FILE_ADDR_LEN
//    byp_hit1/byp_hit2  out  1
//    byp_val1/byp_val2  out  `WORD_SIZE
//  byp_hitN=1 when any stored entry (including the head being popped this cycle) has dest==byp_srcN
//  and byp_srcN!=0. byp_valN is the youngest such entry's data.
//  Same-cycle incoming requests are not searched. byp_hitN=0 forces byp_valN=0.
//  BYPASS_EN undefined: these ports and the search logic are absent; all other behaviour is identical.
// TESTING
//  1 Empty queue; A: dest=5, data=32'hDEADBEEF at edge N
//    -> cycle N+1: write_en=1, dest=5, write_val=DEADBEEF. Cycle N+2: write_en=0.
//  2 A{3,0x11} and B{3,0x22} same cycle
//    -> cycle N+1 writes 0x11, N+2 writes 0x22.
//    -> BYPASS_EN, byp_src1=3 at N+1: hit=1, val=0x22.
//  3 stall=1; enqueue to occupancy 4
//    -> a_ready=b_ready=0.
//    -> stall=0: four writes in enqueue order on consecutive cycles, then occupancy=0.
//  4 Occupancy held at 3 of 4 by stall pulses; a_valid=b_valid=1 continuously
//    -> A accepted 3 times, B accepted on the 4th arbitration, starve counter back to 0.
//  5 A dest=0, data=0xFF
//    -> a_ready=1, occupancy stays 0, write_en never asserts.
//  6 Three entries queued; rst=1 for one edge
//    -> occupancy=0, write_en=0 next cycle, none of the three written.

Source files
------------

// File: rtl/reg_writeback_queue.sv
`default_nettype none

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

// +-----------------------------------------------------------------------------+
// | Module      : reg_writeback_queue                                           |
// | Description : Merges register writeback results from a fast port (A, ALU)   |
// |               and a long-latency port (B, load/mul-div) into a small FIFO    |
// |               and drains one entry per cycle onto the register-file write   |
// |               port, in arrival order. B is protected from starvation when   |
// |               only one slot is free. Writes to x0 are accepted and dropped.  |
// |               Optional macro BYPASS_EN adds two forwarding search ports     |
// |               that look up the youngest queued value for a register.        |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module reg_writeback_queue #(
  parameter int QUEUE_DEPTH       = 4,
  parameter int STARVE_LIMIT      = 3,
  parameter int REG_FILE_ADDR_LEN = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           a_valid,
  output logic                           a_ready,
  input  logic [REG_FILE_ADDR_LEN-1:0]   a_dest,
  input  logic [`WORD_SIZE-1:0]          a_data,
  input  logic                           b_valid,
  output logic                           b_ready,
  input  logic [REG_FILE_ADDR_LEN-1:0]   b_dest,
  input  logic [`WORD_SIZE-1:0]          b_data,
  input  logic                           stall,
  output logic                           write_en,
  output logic [REG_FILE_ADDR_LEN-1:0]   dest,
  output logic [`WORD_SIZE-1:0]          write_val,
  output logic [$clog2(QUEUE_DEPTH):0]   occupancy
`ifdef BYPASS_EN
  ,
  input  logic [REG_FILE_ADDR_LEN-1:0]   byp_src1,
  input  logic [REG_FILE_ADDR_LEN-1:0]   byp_src2,
  output logic                           byp_hit1,
  output logic                           byp_hit2,
  output logic [`WORD_SIZE-1:0]          byp_val1,
  output logic [`WORD_SIZE-1:0]          byp_val2
`endif
);

  localparam int PTR_W  = $clog2(QUEUE_DEPTH);
  localparam int OCC_W  = $clog2(QUEUE_DEPTH) + 1;
  localparam int STV_W  = $clog2(STARVE_LIMIT + 1);
  localparam int DATA_W = `WORD_SIZE;

  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(QUEUE_DEPTH);
  localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);

  // Storage, split into destination and data arrays
  logic [REG_FILE_ADDR_LEN-1:0] mem_dest_q [QUEUE_DEPTH];
  logic [REG_FILE_ADDR_LEN-1:0] mem_dest_d [QUEUE_DEPTH];
  logic [DATA_W-1:0]            mem_data_q [QUEUE_DEPTH];
  logic [DATA_W-1:0]            mem_data_d [QUEUE_DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [STV_W-1:0] starve_q, starve_d;

  logic [OCC_W-1:0] free;
  logic             free_ge2;
  logic             free_eq1;
  logic             starved;
  logic             a_fire;
  logic             b_fire;
  logic             enq_a;
  logic             enq_b;
  logic             pop;
  logic [PTR_W-1:0] wr_ptr_b;

  // Arbitration: readies depend only on start-of-cycle free space, the valids and the starve state
  always_comb begin
    free     = DEPTH_C - occ_q;
    free_ge2 = (free >= OCC_W'(2));
    free_eq1 = (free == OCC_W'(1));
    starved  = (starve_q == LIMIT_C);
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    if (free_ge2) begin
      a_ready = 1'b1;
      b_ready = 1'b1;
    end else if (free_eq1) begin
      if (starved) begin
        b_ready = 1'b1;
        a_ready = !b_valid;
      end else begin
        a_ready = 1'b1;
        b_ready = !a_valid;
      end
    end
  end

  // Handshakes; a write to register 0 completes but is never stored. Reset blocks the drain.
  always_comb begin
    a_fire = a_valid && a_ready;
    b_fire = b_valid && b_ready;
    enq_a  = a_fire && (a_dest != '0);
    enq_b  = b_fire && (b_dest != '0);
    pop    = (occ_q != '0) && !stall && !rst;
  end

  // Pointer and occupancy update; A lands before B when both are stored in one cycle
  always_comb begin
    wr_ptr_b = wr_ptr_q + PTR_W'(enq_a);
    wr_ptr_d = wr_ptr_q + PTR_W'(enq_a) + PTR_W'(enq_b);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    occ_d    = occ_q + OCC_W'(enq_a) + OCC_W'(enq_b) - OCC_W'(pop);
  end

  // Storage write: A at the tail, B right behind it
  always_comb begin
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      mem_dest_d[i] = mem_dest_q[i];
      mem_data_d[i] = mem_data_q[i];
    end
    if (enq_a) begin
      mem_dest_d[wr_ptr_q] = a_dest;
      mem_data_d[wr_ptr_q] = a_data;
    end
    if (enq_b) begin
      mem_dest_d[wr_ptr_b] = b_dest;
      mem_data_d[wr_ptr_b] = b_data;
    end
  end

  // Starvation counter: counts consecutive single-slot losses of B to A, frozen while full
  always_comb begin
    starve_d = starve_q;
    if (free == '0) begin
      starve_d = starve_q;
    end else if (b_valid && !b_ready && free_eq1) begin
      if (!starved) begin
        starve_d = starve_q + STV_W'(1);
      end
    end else if (b_fire || !b_valid) begin
      starve_d = '0;
    end
  end

  // Register-file write port driven straight from the head; idle port shows zeros
  always_comb begin
    write_en  = pop;
    dest      = pop ? mem_dest_q[rd_ptr_q] : '0;
    write_val = pop ? mem_data_q[rd_ptr_q] : '0;
    occupancy = occ_q;
  end

  // Control state registers; reset empties the queue and forgets starvation history
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      starve_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      starve_q <= starve_d;
    end
  end

  // Entry storage; contents are don't-care outside the occupied window so no reset is needed
  always_ff @(posedge clk) begin
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      mem_dest_q[i] <= mem_dest_d[i];
      mem_data_q[i] <= mem_data_d[i];
    end
  end

`ifdef BYPASS_EN
  logic [PTR_W-1:0] byp_idx;

  // Forwarding search over stored entries, oldest to youngest so the youngest match wins
  always_comb begin
    byp_idx  = '0;
    byp_hit1 = 1'b0;
    byp_hit2 = 1'b0;
    byp_val1 = '0;
    byp_val2 = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      byp_idx = rd_ptr_q + PTR_W'(i);
      if (OCC_W'(i) < occ_q) begin
        if ((byp_src1 != '0) && (mem_dest_q[byp_idx] == byp_src1)) begin
          byp_hit1 = 1'b1;
          byp_val1 = mem_data_q[byp_idx];
        end
        if ((byp_src2 != '0) && (mem_dest_q[byp_idx] == byp_src2)) begin
          byp_hit2 = 1'b1;
          byp_val2 = mem_data_q[byp_idx];
        end
      end
    end
  end
`endif

endmodule

`default_nettype wire
